// File: rtl/mole_datapath.sv
// Whack-a-mole game datapath: button conditioning, tick prescaler, game timer, score,
// and the gap/mole/wait phase sequencer that hands advance pulses back to the game FSM.
module mole_datapath #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned GAP_TICKS  = 1,
    parameter int unsigned MOLE_TICKS = 2,
    parameter int unsigned GAME_TICKS = 60,
    parameter int unsigned WAIT_MAX   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] state,
    input  logic [3:0] buttons,
    output logic       control_signal,
    output logic       timer_signal,
    output logic [3:0] mole_leds,
    output logic [7:0] score,
    output logic [7:0] time_left,
    output logic       hit_pulse,
    output logic       miss_pulse
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {PH_IDLE, PH_GAP, PH_UP, PH_WAIT} phase_t;

    logic [3:0]    sync1, sync2, btn_prev, btn_evt;
    logic [PW-1:0] pre_cnt;
    logic          in_play, tick;
    phase_t        phase, cur_phase;
    logic [3:0]    latched;
    logic [CW-1:0] wait_cnt, gap_cnt, mole_cnt;
    logic [CW-1:0] gap_base, mole_base, gap_next, mole_next;
    logic          timeout, active, keep, hit;
    logic [1:0]    mole_idx;

    // Two-flop synchronizer plus registered rising-edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            btn_prev <= '0;
            btn_evt  <= '0;
        end else begin
            sync1    <= buttons;
            sync2    <= sync1;
            btn_prev <= sync2;
            btn_evt  <= sync2 & ~btn_prev;
        end
    end

    // Game tick prescaler, parked at zero outside Game/Mole states
    always_comb begin
        in_play = (state >= 4'd1) && (state <= 4'd5);
        tick    = in_play && (pre_cnt == PW'(TICK_DIV - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pre_cnt <= '0;
        else if (!in_play || tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + PW'(1);
    end

    // Phase selection; a WAIT timeout keeps the old counters so an expired condition re-fires
    always_comb begin
        cur_phase = PH_IDLE;
        case (state)
            4'd1:                      cur_phase = PH_GAP;
            4'd2, 4'd3, 4'd4, 4'd5:    cur_phase = PH_UP;
            default:                   cur_phase = PH_IDLE;
        endcase
        mole_idx  = 2'(state - 4'd2);
        timeout   = (phase == PH_WAIT) && (wait_cnt == CW'(WAIT_MAX - 1));
        active    = (phase != PH_WAIT) || (state != latched) || timeout;
        keep      = (phase == cur_phase) || timeout;
        gap_base  = keep ? gap_cnt : '0;
        mole_base = keep ? mole_cnt : '0;
        gap_next  = (tick && (gap_base < CW'(GAP_TICKS))) ? gap_base + CW'(1) : gap_base;
        mole_next = (tick && (mole_base < CW'(MOLE_TICKS))) ? mole_base + CW'(1) : mole_base;
        hit       = btn_evt[mole_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase          <= PH_IDLE;
            latched        <= '0;
            wait_cnt       <= '0;
            gap_cnt        <= '0;
            mole_cnt       <= '0;
            control_signal <= 1'b0;
            timer_signal   <= 1'b0;
            mole_leds      <= '0;
            score          <= '0;
            time_left      <= 8'(GAME_TICKS);
            hit_pulse      <= 1'b0;
            miss_pulse     <= 1'b0;
        end else begin
            control_signal <= 1'b0;
            hit_pulse      <= 1'b0;
            miss_pulse     <= 1'b0;
            timer_signal   <= (state != 4'd0) && (time_left == 8'd0);

            if (state == 4'd0) begin
                time_left <= 8'(GAME_TICKS);
                score     <= '0;
            end else if (tick && (time_left != 8'd0)) begin
                time_left <= time_left - 8'd1;
            end

            if (!active) begin
                wait_cnt  <= wait_cnt + CW'(1);
                mole_leds <= '0;
            end else begin
                phase     <= cur_phase;
                gap_cnt   <= '0;
                mole_cnt  <= '0;
                wait_cnt  <= '0;
                mole_leds <= '0;
                case (cur_phase)
                    PH_GAP: begin
                        gap_cnt <= gap_next;
                        if ((gap_next >= CW'(GAP_TICKS)) && (time_left != 8'd0) && !control_signal) begin
                            control_signal <= 1'b1;
                            phase          <= PH_WAIT;
                            latched        <= state;
                        end
                    end
                    PH_UP: begin
                        mole_cnt  <= mole_next;
                        mole_leds <= 4'b0001 << mole_idx;
                        // Expired game beats hit, hit beats mole timeout
                        if (!control_signal) begin
                            if (time_left == 8'd0) begin
                                control_signal <= 1'b1;
                                phase          <= PH_WAIT;
                                latched        <= state;
                                mole_leds      <= '0;
                            end else if (hit) begin
                                score          <= (score == 8'hFF) ? score : score + 8'd1;
                                hit_pulse      <= 1'b1;
                                control_signal <= 1'b1;
                                phase          <= PH_WAIT;
                                latched        <= state;
                                mole_leds      <= '0;
                            end else if (mole_next >= CW'(MOLE_TICKS)) begin
                                miss_pulse     <= 1'b1;
                                control_signal <= 1'b1;
                                phase          <= PH_WAIT;
                                latched        <= state;
                                mole_leds      <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mole_datapath.sv
// Directed bench for mole_datapath: the bench plays the game FSM by driving state directly.
module tb_mole_datapath;

    logic       clk;
    logic       reset;
    logic [3:0] state, buttons, state_s, buttons_s;
    logic       control_signal, timer_signal, hit_pulse, miss_pulse;
    logic [3:0] mole_leds;
    logic [7:0] score, time_left;
    logic       control_s, timer_s, hit_s, miss_s;
    logic [3:0] leds_s;
    logic [7:0] score_s, time_s;

    int checks   = 0;
    int failures = 0;

    mole_datapath #(
        .TICK_DIV(4), .GAP_TICKS(1), .MOLE_TICKS(2), .GAME_TICKS(20), .WAIT_MAX(16)
    ) dut (
        .clk(clk), .reset(reset), .state(state), .buttons(buttons),
        .control_signal(control_signal), .timer_signal(timer_signal), .mole_leds(mole_leds),
        .score(score), .time_left(time_left), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    // Slow-tick instance so many hits fit before game time runs out
    mole_datapath #(
        .TICK_DIV(100000), .GAP_TICKS(1), .MOLE_TICKS(2), .GAME_TICKS(20), .WAIT_MAX(16)
    ) dut_sat (
        .clk(clk), .reset(reset), .state(state_s), .buttons(buttons_s),
        .control_signal(control_s), .timer_signal(timer_s), .mole_leds(leds_s),
        .score(score_s), .time_left(time_s), .hit_pulse(hit_s), .miss_pulse(miss_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1; state = 4'd0; buttons = 4'd0; state_s = 4'd0; buttons_s = 4'd0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic wait_pulse(input int bound, output int cyc);
        cyc = 0;
        for (int k = 1; k <= bound; k++) begin
            step(1);
            if (control_signal) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic hit_once_s(input int m, output bit got);
        state_s = 4'(2 + m);
        step(1);
        buttons_s = 4'(1 << m);
        got = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step(1);
            if (hit_s) begin
                got = 1'b1;
                break;
            end
        end
        buttons_s = 4'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1; state = 4'd0; buttons = 4'd0; state_s = 4'd0; buttons_s = 4'd0;
        step(3);
        checks++; if (control_signal !== 1'b0) begin failures++; $display("FAIL reset_control: got %0b expected 0", control_signal); end
        checks++; if (timer_signal !== 1'b0) begin failures++; $display("FAIL reset_timer: got %0b expected 0", timer_signal); end
        checks++; if (mole_leds !== 4'd0) begin failures++; $display("FAIL reset_leds: got %b expected 0000", mole_leds); end
        checks++; if (score !== 8'd0) begin failures++; $display("FAIL reset_score: got %0d expected 0", score); end
        checks++; if (time_left !== 8'd20) begin failures++; $display("FAIL reset_time: got %0d expected 20", time_left); end
        checks++; if ({hit_pulse, miss_pulse} !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b expected 00", {hit_pulse, miss_pulse}); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset_midgame;
        int cyc;
        do_reset;
        state = 4'd1;
        step(3);
        reset = 1'b1;
        step(3);
        checks++; if (control_signal !== 1'b0) begin failures++; $display("FAIL midreset_control: got %0b expected 0", control_signal); end
        checks++; if (time_left !== 8'd20) begin failures++; $display("FAIL midreset_time: got %0d expected 20", time_left); end
        reset = 1'b0;
        wait_pulse(20, cyc);
        checks++; if (cyc != 4) begin failures++; $display("FAIL midreset_pulse_delay: got %0d expected 4", cyc); end
    endtask

    task automatic test_spawn_hit;
        int cyc;
        do_reset;
        state = 4'd1;
        wait_pulse(20, cyc);
        checks++; if (cyc != 4) begin failures++; $display("FAIL spawn_delay: got %0d expected 4", cyc); end
        state = 4'd3;
        step(1);
        checks++; if (control_signal !== 1'b0) begin failures++; $display("FAIL spawn_double_pulse: got %0b expected 0", control_signal); end
        checks++; if (mole_leds !== 4'b0010) begin failures++; $display("FAIL mole2_leds: got %b expected 0010", mole_leds); end
        buttons = 4'b0010;
        wait_pulse(20, cyc);
        checks++; if (cyc != 4) begin failures++; $display("FAIL hit_latency: got %0d expected 4", cyc); end
        checks++; if (hit_pulse !== 1'b1) begin failures++; $display("FAIL hit_pulse: got %0b expected 1", hit_pulse); end
        checks++; if (score !== 8'd1) begin failures++; $display("FAIL hit_score: got %0d expected 1", score); end
        checks++; if (mole_leds !== 4'd0) begin failures++; $display("FAIL hit_leds: got %b expected 0000", mole_leds); end
        buttons = 4'd0;
    endtask

    task automatic test_miss;
        int cyc;
        bit saw_hit;
        do_reset;
        state = 4'd1;
        wait_pulse(20, cyc);
        state = 4'd4;
        step(1);
        checks++; if (mole_leds !== 4'b1000 >> 1) begin failures++; $display("FAIL mole3_leds: got %b expected 0100", mole_leds); end
        buttons = 4'b0001;
        saw_hit = 1'b0;
        cyc = 0;
        for (int j = 2; j <= 20; j++) begin
            step(1);
            if (j == 3) buttons = 4'd0;
            if (hit_pulse) saw_hit = 1'b1;
            if (control_signal) begin
                cyc = j;
                break;
            end
        end
        checks++; if (cyc != 8) begin failures++; $display("FAIL miss_delay: got %0d expected 8", cyc); end
        checks++; if (miss_pulse !== 1'b1) begin failures++; $display("FAIL miss_pulse: got %0b expected 1", miss_pulse); end
        checks++; if (saw_hit !== 1'b0) begin failures++; $display("FAIL wrong_button_hit: got %0b expected 0", saw_hit); end
        checks++; if (score !== 8'd0) begin failures++; $display("FAIL miss_score: got %0d expected 0", score); end
    endtask

    task automatic test_hit_vs_timeout;
        int cyc;
        do_reset;
        state = 4'd1;
        wait_pulse(20, cyc);
        state = 4'd2;
        cyc = 0;
        for (int j = 1; j <= 20; j++) begin
            step(1);
            if (j == 4) buttons = 4'b0001;
            if (j == 6) buttons = 4'd0;
            if (control_signal) begin
                cyc = j;
                break;
            end
        end
        checks++; if (cyc != 8) begin failures++; $display("FAIL tie_delay: got %0d expected 8", cyc); end
        checks++; if ({hit_pulse, miss_pulse} !== 2'b10) begin failures++; $display("FAIL tie_pulses: got %b expected 10", {hit_pulse, miss_pulse}); end
        checks++; if (score !== 8'd1) begin failures++; $display("FAIL tie_score: got %0d expected 1", score); end
    endtask

    task automatic test_game_over;
        int t, hit_t, zero_t;
        do_reset;
        state = 4'd2;
        step(1);
        buttons = 4'b0001;
        hit_t = 0;
        t = 1;
        while (t < 12) begin
            t++;
            step(1);
            if (hit_pulse) begin
                hit_t = t;
                break;
            end
        end
        checks++; if (hit_t != 5) begin failures++; $display("FAIL game_hit_time: got %0d expected 5", hit_t); end
        buttons = 4'd0;
        state = 4'd1;
        zero_t = 0;
        while (t < 120) begin
            t++;
            step(1);
            if (time_left == 8'd0) begin
                zero_t = t;
                break;
            end
        end
        checks++; if (zero_t != 80) begin failures++; $display("FAIL time_expiry: got %0d expected 80", zero_t); end
        checks++; if (timer_signal !== 1'b0) begin failures++; $display("FAIL timer_early: got %0b expected 0", timer_signal); end
        step(1);
        checks++; if (timer_signal !== 1'b1) begin failures++; $display("FAIL timer_set: got %0b expected 1", timer_signal); end
        state = 4'd3;
        step(1);
        checks++; if (control_signal !== 1'b1) begin failures++; $display("FAIL expired_mole_pulse: got %0b expected 1", control_signal); end
        checks++; if ({hit_pulse, miss_pulse} !== 2'b00) begin failures++; $display("FAIL expired_mole_pulses: got %b expected 00", {hit_pulse, miss_pulse}); end
        state = 4'd6;
        step(2);
        checks++; if (score !== 8'd1) begin failures++; $display("FAIL gameover_score: got %0d expected 1", score); end
        checks++; if (time_left !== 8'd0) begin failures++; $display("FAIL gameover_time: got %0d expected 0", time_left); end
        state = 4'd0;
        step(1);
        checks++; if (time_left !== 8'd20) begin failures++; $display("FAIL restart_time: got %0d expected 20", time_left); end
        checks++; if (score !== 8'd0) begin failures++; $display("FAIL restart_score: got %0d expected 0", score); end
        checks++; if (timer_signal !== 1'b0) begin failures++; $display("FAIL restart_timer: got %0b expected 0", timer_signal); end
    endtask

    task automatic test_wait_timeout;
        int cyc;
        do_reset;
        state = 4'd1;
        wait_pulse(20, cyc);
        checks++; if (cyc != 4) begin failures++; $display("FAIL wait_first_pulse: got %0d expected 4", cyc); end
        wait_pulse(40, cyc);
        checks++; if (cyc != 16) begin failures++; $display("FAIL wait_second_pulse: got %0d expected 16", cyc); end
    endtask

    task automatic test_saturation;
        int missed;
        bit got;
        do_reset;
        missed = 0;
        for (int i = 0; i < 255; i++) begin
            hit_once_s(i % 2, got);
            if (!got) missed++;
        end
        checks++; if (missed != 0) begin failures++; $display("FAIL sat_lost_hits: got %0d expected 0", missed); end
        checks++; if (score_s !== 8'd255) begin failures++; $display("FAIL sat_reach: got %0d expected 255", score_s); end
        hit_once_s(1, got);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL sat_hit_pulse: got %0b expected 1", got); end
        checks++; if (score_s !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d expected 255", score_s); end
        checks++; if (control_s !== 1'b1) begin failures++; $display("FAIL sat_control: got %0b expected 1", control_s); end
    endtask

    initial begin
        test_reset;
        test_reset_midgame;
        test_spawn_hit;
        test_miss;
        test_hit_vs_timeout;
        test_game_over;
        test_wait_timeout;
        test_saturation;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
